// File: rtl/game_round_controller.sv
// Round sequencer for the two-player shooting game.
// Owns the round state machine, both health counters, the countdown digit
// and the per-frame datapath update strobe. Single clock domain (game_clk).
module game_round_controller #(
  parameter int MAX_HEALTH      = 2,
  parameter int COUNT_FRAMES    = 60,
  parameter int FREEZE_FRAMES   = 20,
  parameter int WIN_HOLD_FRAMES = 120
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       frame_tick_i,
  input  logic       start_i,
  input  logic       hit_p1_i,
  input  logic       hit_p2_i,
  output logic [2:0] state_o,
  output logic       run_en_o,
  output logic       load_pos_o,
  output logic [1:0] countdown_o,
  output logic [1:0] p1_health_o,
  output logic [1:0] p2_health_o
);

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    COUNTDOWN = 3'd1,
    RUNNING   = 3'd2,
    FREEZE    = 3'd3,
    WIN_P1    = 3'd4,
    WIN_P2    = 3'd5,
    DRAW      = 3'd6
  } state_t;

  localparam logic [6:0] CNT_MAX     = 7'd127;
  localparam logic [6:0] COUNT_LAST  = 7'(COUNT_FRAMES - 1);
  localparam logic [6:0] FREEZE_LAST = 7'(FREEZE_FRAMES - 1);
  localparam logic [6:0] WIN_HOLD    = 7'(WIN_HOLD_FRAMES);
  localparam logic [1:0] HEALTH_FULL = 2'(MAX_HEALTH);

  state_t     state_q, state_d;
  logic [6:0] frameCnt_q, frameCnt_d;
  logic [1:0] countdown_q, countdown_d;
  logic [1:0] p1Health_q, p1Health_d;
  logic [1:0] p2Health_q, p2Health_d;
  logic       runEn_q, runEn_d;
  logic       loadPos_q, loadPos_d;
  logic       start_q;

  logic       press;
  logic [6:0] cntInc;
  logic [1:0] p1Dec;
  logic [1:0] p2Dec;

  assign press  = start_i & ~start_q;
  assign cntInc = (frameCnt_q == CNT_MAX) ? frameCnt_q : frameCnt_q + 7'd1;
  assign p1Dec  = (hit_p1_i && p1Health_q != 2'd0) ? p1Health_q - 2'd1 : p1Health_q;
  assign p2Dec  = (hit_p2_i && p2Health_q != 2'd0) ? p2Health_q - 2'd1 : p2Health_q;

  // Next-state decode: round transitions, health updates and frame counting.
  always_comb begin
    state_d     = state_q;
    frameCnt_d  = frame_tick_i ? cntInc : frameCnt_q;
    countdown_d = countdown_q;
    p1Health_d  = p1Health_q;
    p2Health_d  = p2Health_q;
    runEn_d     = (state_q == RUNNING) && frame_tick_i;
    loadPos_d   = 1'b0;
    case (state_q)
      MENU: begin
        if (press) begin
          state_d     = COUNTDOWN;
          frameCnt_d  = 7'd0;
          countdown_d = 2'd3;
          p1Health_d  = HEALTH_FULL;
          p2Health_d  = HEALTH_FULL;
          loadPos_d   = 1'b1;
        end
      end
      COUNTDOWN: begin
        // The counter restarts at each digit step because it cannot hold a full 3-step count.
        if (frame_tick_i && frameCnt_q == COUNT_LAST) begin
          frameCnt_d = 7'd0;
          if (countdown_q <= 2'd1) begin
            state_d     = RUNNING;
            countdown_d = 2'd0;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end
      RUNNING: begin
        if (hit_p1_i || hit_p2_i) begin
          p1Health_d = p1Dec;
          p2Health_d = p2Dec;
          frameCnt_d = 7'd0;
          if (p1Dec == 2'd0 && p2Dec == 2'd0) begin
            state_d = DRAW;
          end else if (p1Dec == 2'd0) begin
            state_d = WIN_P2;
          end else if (p2Dec == 2'd0) begin
            state_d = WIN_P1;
          end else begin
            state_d = FREEZE;
          end
        end
      end
      FREEZE: begin
        if (frame_tick_i && frameCnt_q == FREEZE_LAST) begin
          state_d    = RUNNING;
          frameCnt_d = 7'd0;
        end
      end
      WIN_P1, WIN_P2, DRAW: begin
        // Presses before the hold time has elapsed are simply dropped.
        if (press && frameCnt_q >= WIN_HOLD) begin
          state_d    = MENU;
          frameCnt_d = 7'd0;
        end
      end
      default: begin
        state_d     = MENU;
        frameCnt_d  = 7'd0;
        countdown_d = 2'd0;
      end
    endcase
  end

  // State and output registers; start_q resets high so a held button is not a press.
  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) begin
      state_q     <= MENU;
      frameCnt_q  <= 7'd0;
      countdown_q <= 2'd0;
      p1Health_q  <= HEALTH_FULL;
      p2Health_q  <= HEALTH_FULL;
      runEn_q     <= 1'b0;
      loadPos_q   <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      frameCnt_q  <= frameCnt_d;
      countdown_q <= countdown_d;
      p1Health_q  <= p1Health_d;
      p2Health_q  <= p2Health_d;
      runEn_q     <= runEn_d;
      loadPos_q   <= loadPos_d;
      start_q     <= start_i;
    end
  end

  assign state_o     = state_q;
  assign run_en_o    = runEn_q;
  assign load_pos_o  = loadPos_q;
  assign countdown_o = countdown_q;
  assign p1_health_o = p1Health_q;
  assign p2_health_o = p2Health_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: reset/start table, hand-written round
// sequences and a long random run, all checked against a round-level model.
module tb_game_round_controller;

  localparam int MAXH   = 2;
  localparam int COUNTF = 60;
  localparam int FREEZF = 20;
  localparam int HOLDF  = 120;

  localparam int S_MENU = 0, S_CD = 1, S_RUN = 2, S_FRZ = 3, S_W1 = 4, S_W2 = 5, S_DRAW = 6;

  logic       game_clk;
  logic       reset;
  logic       frameTick, start, hitP1, hitP2;
  logic [2:0] stateO;
  logic       runEnO, loadPosO;
  logic [1:0] countdownO, p1O, p2O;
  logic [11:0] dutVec;

  int checks = 0;
  int errors = 0;

  // Model of the round: ticks counted since entering the current state, unbounded.
  int mState, mP1, mP2, mTicks;
  bit mStartPrev, mRunEn, mLoad;

  typedef struct {
    string name;
    bit    tick;
    bit    st;
    bit    h1;
    bit    h2;
    logic [11:0] exp;
  } vec_t;

  vec_t table_q[6];

  game_round_controller #(
    .MAX_HEALTH(MAXH), .COUNT_FRAMES(COUNTF), .FREEZE_FRAMES(FREEZF), .WIN_HOLD_FRAMES(HOLDF)
  ) dut (
    .game_clk(game_clk), .reset(reset), .frame_tick_i(frameTick), .start_i(start),
    .hit_p1_i(hitP1), .hit_p2_i(hitP2), .state_o(stateO), .run_en_o(runEnO),
    .load_pos_o(loadPosO), .countdown_o(countdownO), .p1_health_o(p1O), .p2_health_o(p2O)
  );

  assign dutVec = {stateO, runEnO, loadPosO, countdownO, p1O, p2O};

  // Free-running game clock.
  initial game_clk = 1'b0;
  always #5 game_clk = ~game_clk;

  function automatic logic [11:0] mkVec(int st, bit run, bit ld, int cd, int p1, int p2);
    return {3'(st), run, ld, 2'(cd), 2'(p1), 2'(p2)};
  endfunction

  function automatic logic [11:0] modelVec();
    int cd;
    cd = (mState == S_CD) ? 3 - mTicks / COUNTF : 0;
    return mkVec(mState, mRunEn, mLoad, cd, mP1, mP2);
  endfunction

  task automatic resetModel();
    mState = S_MENU; mP1 = MAXH; mP2 = MAXH; mTicks = 0;
    mStartPrev = 1'b1; mRunEn = 1'b0; mLoad = 1'b0;
  endtask

  task automatic modelStep(input bit tick, input bit st, input bit h1, input bit h2);
    bit press;
    bit nextRun;
    press      = st && !mStartPrev;
    nextRun    = (mState == S_RUN) && tick;
    mStartPrev = st;
    mLoad      = 1'b0;
    case (mState)
      S_MENU: if (press) begin
        mState = S_CD; mTicks = 0; mP1 = MAXH; mP2 = MAXH; mLoad = 1'b1;
      end
      S_CD: if (tick) begin
        mTicks++;
        if (mTicks == 3 * COUNTF) begin mState = S_RUN; mTicks = 0; end
      end
      S_RUN: begin
        if (h1 || h2) begin
          if (h1 && mP1 > 0) mP1--;
          if (h2 && mP2 > 0) mP2--;
          if (mP1 == 0 && mP2 == 0) mState = S_DRAW;
          else if (mP1 == 0)        mState = S_W2;
          else if (mP2 == 0)        mState = S_W1;
          else                      mState = S_FRZ;
          mTicks = 0;
        end else if (tick) begin
          mTicks++;
        end
      end
      S_FRZ: if (tick) begin
        mTicks++;
        if (mTicks == FREEZF) begin mState = S_RUN; mTicks = 0; end
      end
      default: begin
        if (press && mTicks >= HOLDF) begin mState = S_MENU; mTicks = 0; end
        else if (tick) mTicks++;
      end
    endcase
    mRunEn = nextRun;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] exp);
    checks++;
    if (dutVec !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d run=%0b ld=%0b cd=%0d hp=%0d/%0d, want st=%0d run=%0b ld=%0b cd=%0d hp=%0d/%0d",
               name, dutVec[11:9], dutVec[8], dutVec[7], dutVec[6:5], dutVec[3:2], dutVec[1:0],
               exp[11:9], exp[8], exp[7], exp[6:5], exp[3:2], exp[1:0]);
    end
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, compare just after.
  task automatic applyStimulus(input bit tick, input bit st, input bit h1, input bit h2);
    frameTick = tick; start = st; hitP1 = h1; hitP2 = h2;
    @(posedge game_clk);
    modelStep(tick, st, h1, h2);
    #1;
    checkOutput("cycle", modelVec());
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pressStart();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; frameTick = 1'b0; start = 1'b1; hitP1 = 1'b0; hitP2 = 1'b0;
    resetModel();
    repeat (3) @(posedge game_clk);
    #1;
    checkOutput("reset", mkVec(S_MENU, 0, 0, 0, MAXH, MAXH));
    #2 reset = 1'b0;

    // Start held through reset, then release and press; presses/hits in countdown ignored.
    table_q[0] = '{"held_start",   0, 1, 0, 0, mkVec(S_MENU, 0, 0, 0, 2, 2)};
    table_q[1] = '{"release",      0, 0, 0, 0, mkVec(S_MENU, 0, 0, 0, 2, 2)};
    table_q[2] = '{"press",        0, 1, 0, 0, mkVec(S_CD,   0, 1, 3, 2, 2)};
    table_q[3] = '{"load_1cycle",  1, 1, 0, 0, mkVec(S_CD,   0, 0, 3, 2, 2)};
    table_q[4] = '{"hit_in_cd",    0, 0, 1, 1, mkVec(S_CD,   0, 0, 3, 2, 2)};
    table_q[5] = '{"press_in_cd",  0, 1, 0, 0, mkVec(S_CD,   0, 0, 3, 2, 2)};
    for (int i = 0; i < 6; i++) begin
      frameTick = table_q[i].tick; start = table_q[i].st;
      hitP1 = table_q[i].h1; hitP2 = table_q[i].h2;
      @(posedge game_clk);
      modelStep(table_q[i].tick, table_q[i].st, table_q[i].h1, table_q[i].h2);
      #1;
      checkOutput(table_q[i].name, table_q[i].exp);
    end

    // Countdown: one tick already seen, digit steps every 60 ticks.
    runTicks(59);
    checkOutput("cd_digit2", mkVec(S_CD, 0, 0, 2, 2, 2));
    runTicks(60);
    checkOutput("cd_digit1", mkVec(S_CD, 0, 0, 1, 2, 2));
    runTicks(59);
    checkOutput("cd_tick179", mkVec(S_CD, 0, 0, 1, 2, 2));
    runTicks(1);
    checkOutput("cd_done", mkVec(S_RUN, 0, 0, 0, 2, 2));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("run_en_pulse", mkVec(S_RUN, 1, 0, 0, 2, 2));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("run_en_drop", mkVec(S_RUN, 0, 0, 0, 2, 2));

    // Two hits on player 2 separated by a freeze; hit on player 1 during freeze ignored.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("p2_hit1", mkVec(S_FRZ, 0, 0, 0, 2, 1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("hit_in_freeze", mkVec(S_FRZ, 0, 0, 0, 2, 1));
    runTicks(19);
    checkOutput("freeze_19", mkVec(S_FRZ, 0, 0, 0, 2, 1));
    runTicks(1);
    checkOutput("freeze_end", mkVec(S_RUN, 0, 0, 0, 2, 1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("p2_hit2_tick", mkVec(S_W1, 1, 0, 0, 2, 0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("win_run_en", mkVec(S_W1, 0, 0, 0, 2, 0));

    // Result hold: early press dropped, press after the hold time returns to the menu.
    runTicks(49);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("early_press", mkVec(S_W1, 0, 0, 0, 2, 0));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("hit_in_win", mkVec(S_W1, 0, 0, 0, 2, 0));
    runTicks(69);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("press_at_119", mkVec(S_W1, 0, 0, 0, 2, 0));
    runTicks(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("press_at_120", mkVec(S_MENU, 0, 0, 0, 2, 0));

    // Simultaneous hits at 1/1 end in a draw with the datapath stopped.
    pressStart();
    checkOutput("round2_start", mkVec(S_CD, 0, 1, 3, 2, 2));
    runTicks(180);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runTicks(20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("health_1_1", mkVec(S_FRZ, 0, 0, 0, 1, 1));
    runTicks(20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("draw", mkVec(S_DRAW, 0, 0, 0, 0, 0));
    runTicks(5);
    checkOutput("draw_run_en", mkVec(S_DRAW, 0, 0, 0, 0, 0));

    // Reset mid-round at 1/2 with start held: immediate menu, no press afterwards.
    runTicks(115);
    pressStart();
    pressStart();
    runTicks(180);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runTicks(20);
    checkOutput("pre_reset", mkVec(S_RUN, 0, 0, 0, 1, 2));
    #2;
    start = 1'b1; frameTick = 1'b1;
    reset = 1'b1;
    resetModel();
    #1;
    checkOutput("async_reset", mkVec(S_MENU, 0, 0, 0, 2, 2));
    @(posedge game_clk);
    #3 reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("held_after_reset", mkVec(S_MENU, 0, 0, 0, 2, 2));

    // Random traffic checked cycle by cycle against the model.
    begin
      bit stLevel;
      stLevel = 1'b1;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(0, 19) == 0) stLevel = ~stLevel;
        applyStimulus($urandom_range(0, 1) == 1, stLevel,
                      $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
